// File: rtl/whack_game_ctrl.sv
// whack_game_ctrl
// Game core for the LED reaction game: game FSM, latched difficulty level,
// LFSR lane spawner, per-lane LED lifetimes and switch-hit scoring.
//
// Ports
//   CLOCK_50   in   system clock
//   rst        in   synchronous, active-high reset
//   start      in   1-cycle pulse, begins a round (ignored while playing)
//   lvl_req    in   1-cycle pulses, bit k selects level k (lowest bit wins)
//   switches   in   SW inputs, already synchronised
//   leds       out  LED drive
//   score      out  current / last score (saturating)
//   time_left  out  seconds remaining in the round
//   level      out  latched level
//   state      out  0 IDLE, 1 PLAY, 2 OVER
//   misses     out  expiries this round (saturates at 255)
//
// Input handshake: start and lvl_req are single-cycle strobes sampled on the
// rising clock edge; there is no ready, a strobe outside IDLE/OVER is dropped.
module whack_game_ctrl #(
  parameter int N_LEDS    = 18,
  parameter int SCORE_W   = 12,
  parameter int TICK_DIV  = 50000,
  parameter int SEC_TICKS = 1000,
  parameter int ROUND_S   = 30,
  parameter int LIFE0     = 1500,
  parameter int LIFE1     = 1000,
  parameter int LIFE2     = 500,
  parameter int MAX_MISS  = 8,
  parameter int PENALTY   = 1
) (
  input  logic               CLOCK_50,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         lvl_req,
  input  logic [N_LEDS-1:0]  switches,
  output logic [N_LEDS-1:0]  leds,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         time_left,
  output logic [1:0]         level,
  output logic [1:0]         state,
  output logic [7:0]         misses
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N_LEDS-1:0]   leds_q, leds_d, sw_prev_q;
  logic [N_LEDS-1:0]   rise, hit, pen, expire;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [7:0]          time_q, time_d, misses_q, misses_d;
  logic [1:0]          level_q, level_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [31:0]         presc_q, presc_d, sec_q, sec_d, spawn_q, spawn_d;
  logic                pending_q, pending_d;
  logic [15:0]         timer_q [N_LEDS];
  logic [15:0]         timer_d [N_LEDS];
  logic                tick, spawn_ok, timeout, miss_out;
  logic [4:0]          idx;
  logic [31:0]         leds_pad;
  logic [5:0]          hit_cnt, pen_cnt, exp_cnt;
  logic signed [SCORE_W+5:0] score_sum;
  logic [8:0]          miss_sum;

  function automatic logic [15:0] life_of(input logic [1:0] l);
    case (l)
      2'd0:    return 16'(LIFE0);
      2'd1:    return 16'(LIFE1);
      default: return 16'(LIFE2);
    endcase
  endfunction

  function automatic logic [1:0] pick_level(input logic [2:0] req, input logic [1:0] cur);
    if (req[0])      return 2'd0;
    else if (req[1]) return 2'd1;
    else if (req[2]) return 2'd2;
    else             return cur;
  endfunction

  assign tick     = (presc_q == 32'(TICK_DIV - 1));
  assign presc_d  = tick ? 32'd0 : presc_q + 32'd1;
  // Taps 16,14,13,11 in right-shift form; runs in every state.
  assign lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  assign rise     = switches & ~sw_prev_q;
  assign idx      = lfsr_q[4:0];
  // Zero-padded copy so a spawn index beyond N_LEDS never reads out of range.
  assign leds_pad = 32'(leds_q);

  always_comb begin
    state_d   = state_q;
    leds_d    = leds_q;
    score_d   = score_q;
    time_d    = time_q;
    misses_d  = misses_q;
    level_d   = level_q;
    sec_d     = sec_q;
    spawn_d   = spawn_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    hit       = '0;
    pen       = '0;
    expire    = '0;
    hit_cnt   = '0;
    pen_cnt   = '0;
    exp_cnt   = '0;
    score_sum = '0;
    miss_sum  = '0;
    timeout   = 1'b0;
    miss_out  = 1'b0;
    spawn_ok  = 1'b0;

    case (state_q)
      S_PLAY: begin
        // Lanes that are lit (hit or expiring) are never spawn targets.
        spawn_ok = pending_q && (32'(idx) < 32'(N_LEDS)) && !leds_pad[idx];
        for (int i = 0; i < N_LEDS; i++) begin
          if (leds_q[i] && rise[i]) begin
            // A hit takes priority over an expiry in the same cycle.
            hit[i]     = 1'b1;
            leds_d[i]  = 1'b0;
            timer_d[i] = 16'd0;
          end else if (leds_q[i] && tick) begin
            if (timer_q[i] == 16'd1) begin
              expire[i]  = 1'b1;
              leds_d[i]  = 1'b0;
              timer_d[i] = 16'd0;
            end else begin
              timer_d[i] = timer_q[i] - 16'd1;
            end
          end else if (!leds_q[i] && rise[i]) begin
            pen[i] = 1'b1;
          end
          if (spawn_ok && idx == 5'(i)) begin
            leds_d[i]  = 1'b1;
            timer_d[i] = life_of(level_q);
          end
          hit_cnt = hit_cnt + 6'(hit[i]);
          pen_cnt = pen_cnt + 6'(pen[i]);
          exp_cnt = exp_cnt + 6'(expire[i]);
        end
        if (spawn_ok) pending_d = 1'b0;
        if (tick) begin
          if (spawn_q == 32'd1) begin
            pending_d = 1'b1;
            spawn_d   = 32'(life_of(level_q)) >> 1;
          end else begin
            spawn_d = spawn_q - 32'd1;
          end
          if (sec_q == 32'(SEC_TICKS - 1)) begin
            sec_d   = 32'd0;
            time_d  = time_q - 8'd1;
            timeout = (time_q == 8'd1);
          end else begin
            sec_d = sec_q + 32'd1;
          end
        end
        score_sum = $signed({6'b0, score_q}) + $signed({{SCORE_W{1'b0}}, hit_cnt});
        if (PENALTY != 0) score_sum = score_sum - $signed({{SCORE_W{1'b0}}, pen_cnt});
        if (score_sum < 0)
          score_d = '0;
        else if (score_sum > $signed({6'b0, {SCORE_W{1'b1}}}))
          score_d = '1;
        else
          score_d = score_sum[SCORE_W-1:0];
        miss_sum = {1'b0, misses_q} + {3'b0, exp_cnt};
        misses_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        miss_out = (MAX_MISS != 0) && (misses_d >= 8'(MAX_MISS));
        if (timeout || miss_out) begin
          state_d   = S_OVER;
          leds_d    = '1;
          sec_d     = 32'd0;
          pending_d = 1'b0;
          for (int i = 0; i < N_LEDS; i++) timer_d[i] = 16'd0;
        end
      end
      S_OVER: begin
        level_d = pick_level(lvl_req, level_q);
        // sec counter is reused as the blink half-period counter.
        if (tick) begin
          if (sec_q == 32'(SEC_TICKS / 2 - 1)) begin
            sec_d  = 32'd0;
            leds_d = ~leds_q;
          end else begin
            sec_d = sec_q + 32'd1;
          end
        end
      end
      default: begin
        level_d = pick_level(lvl_req, level_q);
        leds_d  = '0;
      end
    endcase

    if (state_q != S_PLAY && start) begin
      state_d   = S_PLAY;
      score_d   = '0;
      misses_d  = '0;
      time_d    = 8'(ROUND_S);
      leds_d    = '0;
      sec_d     = 32'd0;
      pending_d = 1'b0;
      spawn_d   = 32'(life_of(level_d)) >> 1;
      for (int i = 0; i < N_LEDS; i++) timer_d[i] = 16'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    sw_prev_q <= switches;
    if (rst) begin
      state_q   <= S_IDLE;
      leds_q    <= '0;
      score_q   <= '0;
      time_q    <= 8'(ROUND_S);
      misses_q  <= '0;
      level_q   <= 2'd0;
      lfsr_q    <= 16'hACE1;
      presc_q   <= 32'd0;
      sec_q     <= 32'd0;
      spawn_q   <= 32'd0;
      pending_q <= 1'b0;
      for (int i = 0; i < N_LEDS; i++) timer_q[i] <= 16'd0;
    end else begin
      state_q   <= state_d;
      leds_q    <= leds_d;
      score_q   <= score_d;
      time_q    <= time_d;
      misses_q  <= misses_d;
      level_q   <= level_d;
      lfsr_q    <= lfsr_d;
      presc_q   <= presc_d;
      sec_q     <= sec_d;
      spawn_q   <= spawn_d;
      pending_q <= pending_d;
      for (int i = 0; i < N_LEDS; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign leds      = leds_q;
  assign score     = score_q;
  assign time_left = time_q;
  assign level     = level_q;
  assign state     = state_q;
  assign misses    = misses_q;

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Testbench for whack_game_ctrl: two instances (miss limit off / miss limit 2)
// share the same stimulus and are compared every cycle against a lane-life
// model of the game rules, plus directed literal checks.
module tb_whack_game_ctrl;
  localparam int N = 18, SW = 3, TD = 4, ST = 10, RS = 3;
  localparam int L0 = 8, L1 = 6, L2 = 4, PEN = 1;

  // ---------------- clock / reset / inputs ----------------
  logic          CLOCK_50 = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    lvl_req = 3'b0;
  logic [N-1:0]  switches = '0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic [N-1:0]  a_leds, b_leds;
  logic [SW-1:0] a_score, b_score;
  logic [7:0]    a_time, b_time, a_miss, b_miss;
  logic [1:0]    a_lvl, b_lvl, a_st, b_st;

  whack_game_ctrl #(.N_LEDS(N), .SCORE_W(SW), .TICK_DIV(TD), .SEC_TICKS(ST), .ROUND_S(RS),
    .LIFE0(L0), .LIFE1(L1), .LIFE2(L2), .MAX_MISS(0), .PENALTY(PEN)) dut_a (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .lvl_req(lvl_req), .switches(switches),
    .leds(a_leds), .score(a_score), .time_left(a_time), .level(a_lvl), .state(a_st),
    .misses(a_miss));

  whack_game_ctrl #(.N_LEDS(N), .SCORE_W(SW), .TICK_DIV(TD), .SEC_TICKS(ST), .ROUND_S(RS),
    .LIFE0(L0), .LIFE1(L1), .LIFE2(L2), .MAX_MISS(2), .PENALTY(PEN)) dut_b (
    .CLOCK_50(CLOCK_50), .rst(rst), .start(start), .lvl_req(lvl_req), .switches(switches),
    .leds(b_leds), .score(b_score), .time_left(b_time), .level(b_lvl), .state(b_st),
    .misses(b_miss));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each lane holds its remaining life in ticks (0 = dark). Round time is the
  // count of elapsed ticks; blink phase is ticks since the round ended.
  int m_st[2], m_score[2], m_miss[2], m_e[2], m_o[2], m_lvl[2], m_pend[2];
  int m_life[2][N];
  int max_miss[2] = '{0, 2};
  logic [15:0] m_lfsr;
  logic [N-1:0] m_swp, m_rise;
  int cyc;
  bit m_tk;
  bit m_valid = 1'b0;

  function automatic int life_of(input int l);
    return (l == 0) ? L0 : (l == 1) ? L1 : L2;
  endfunction

  task automatic model_step(input int k, input bit tk, input logic [N-1:0] rise);
    int hits, pens, exps, id;
    bit can;
    hits = 0; pens = 0; exps = 0; can = 1'b0;
    if (m_st[k] != 1) begin
      if (lvl_req[0]) m_lvl[k] = 0;
      else if (lvl_req[1]) m_lvl[k] = 1;
      else if (lvl_req[2]) m_lvl[k] = 2;
      if (m_st[k] == 2 && tk) m_o[k]++;
      if (start) begin
        m_st[k] = 1; m_score[k] = 0; m_miss[k] = 0; m_e[k] = 0; m_pend[k] = 0;
        for (int i = 0; i < N; i++) m_life[k][i] = 0;
      end
    end else begin
      id = int'(m_lfsr[4:0]);
      if (m_pend[k] != 0 && id < N) can = (m_life[k][id] == 0);
      for (int i = 0; i < N; i++) begin
        if (m_life[k][i] > 0) begin
          if (rise[i]) begin
            hits++; m_life[k][i] = 0;
          end else if (tk) begin
            m_life[k][i]--;
            if (m_life[k][i] == 0) exps++;
          end
        end else if (rise[i]) begin
          pens++;
        end
      end
      if (can) begin
        m_life[k][id] = life_of(m_lvl[k]);
        m_pend[k] = 0;
      end
      m_score[k] = m_score[k] + hits - PEN * pens;
      if (m_score[k] < 0) m_score[k] = 0;
      if (m_score[k] > (1 << SW) - 1) m_score[k] = (1 << SW) - 1;
      m_miss[k] = m_miss[k] + exps;
      if (m_miss[k] > 255) m_miss[k] = 255;
      if (tk) begin
        m_e[k]++;
        if (m_e[k] % (life_of(m_lvl[k]) / 2) == 0) m_pend[k] = 1;
      end
      if (m_e[k] == RS * ST || (max_miss[k] != 0 && m_miss[k] >= max_miss[k])) begin
        m_st[k] = 2; m_o[k] = 0; m_pend[k] = 0;
        for (int i = 0; i < N; i++) m_life[k][i] = 0;
      end
    end
  endtask

  always @(posedge CLOCK_50) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = 0; m_score[k] = 0; m_miss[k] = 0; m_e[k] = 0; m_o[k] = 0;
        m_lvl[k] = 0; m_pend[k] = 0;
        for (int i = 0; i < N; i++) m_life[k][i] = 0;
      end
      m_lfsr = 16'hACE1;
      m_swp = switches;
      cyc = 0;
      m_valid = 1'b1;
    end else begin
      m_tk = ((cyc % TD) == TD - 1);
      cyc++;
      m_rise = switches & ~m_swp;
      for (int k = 0; k < 2; k++) model_step(k, m_tk, m_rise);
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      m_swp = switches;
    end
  end

  function automatic logic [N-1:0] exp_leds(input int k);
    logic [N-1:0] v;
    v = '0;
    if (m_st[k] == 1) begin
      for (int i = 0; i < N; i++) v[i] = (m_life[k][i] > 0);
    end else if (m_st[k] == 2) begin
      v = (((m_o[k] / (ST / 2)) % 2) == 0) ? '1 : '0;
    end
    return v;
  endfunction

  // ---------------- per-cycle scoreboard compare ----------------
  task automatic cmp(input int k, input logic [N-1:0] l, input logic [SW-1:0] s,
                     input logic [7:0] t, input logic [1:0] lv, input logic [1:0] st,
                     input logic [7:0] ms);
    chk($sformatf("leds%0d", k), 32'(l), 32'(exp_leds(k)));
    chk($sformatf("score%0d", k), 32'(s), 32'(m_score[k]));
    chk($sformatf("time%0d", k), 32'(t), 32'(RS - m_e[k] / ST));
    chk($sformatf("level%0d", k), 32'(lv), 32'(m_lvl[k]));
    chk($sformatf("state%0d", k), 32'(st), 32'(m_st[k]));
    chk($sformatf("misses%0d", k), 32'(ms), 32'(m_miss[k]));
  endtask

  always @(negedge CLOCK_50) begin
    if (m_valid) begin
      cmp(0, a_leds, a_score, a_time, a_lvl, a_st, a_miss);
      cmp(1, b_leds, b_score, b_time, b_lvl, b_st, b_miss);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  task automatic new_round(input logic [2:0] lv);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (m_st[0] != 1 && m_st[1] != 1) begin ok = 1'b1; break; end
      step();
    end
    chk("round_wait", 32'(ok), 32'd1);
    switches = '0;
    lvl_req = lv;
    step();
    lvl_req = 3'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_lit(input int need, output int l0, output int l1, output bit ok);
    int cnt;
    ok = 1'b0; l0 = 0; l1 = 0;
    for (int c = 0; c < 300; c++) begin
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        if (m_st[0] == 1 && m_life[0][i] > 0) begin
          if (cnt == 0) l0 = i; else if (cnt == 1) l1 = i;
          cnt++;
        end
      end
      if (cnt >= need) begin ok = 1'b1; break; end
      step();
    end
    chk("wait_lit", 32'(ok), 32'd1);
  endtask

  task automatic do_hit(input int exp_score, input string nm);
    int l0, l1;
    bit ok;
    wait_lit(1, l0, l1, ok);
    if (ok) begin
      switches[l0] = 1'b1;
      step();
      @(negedge CLOCK_50);
      chk({nm, "_led"}, 32'(a_leds[l0]), 32'd0);
      chk(nm, 32'(a_score), 32'(exp_score));
      step();
      switches = '0;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int l0, l1, r, id, off, j;
    bit ok;

    step(2);
    rst = 1'b0;
    @(negedge CLOCK_50);
    chk("rst_state", 32'(a_st), 32'd0);
    chk("rst_leds", 32'(a_leds), 32'd0);
    chk("rst_score", 32'(a_score), 32'd0);
    chk("rst_time", 32'(a_time), 32'd3);
    chk("rst_level", 32'(a_lvl), 32'd0);
    chk("rst_misses", 32'(a_miss), 32'd0);

    step();
    lvl_req = 3'b100;
    step();
    lvl_req = 3'b000;
    @(negedge CLOCK_50);
    chk("level_set", 32'(a_lvl), 32'd2);
    step(100);
    @(negedge CLOCK_50);
    chk("level_held", 32'(a_lvl), 32'd2);

    step();
    start = 1'b1;
    step();
    start = 1'b0;
    @(negedge CLOCK_50);
    chk("start_state", 32'(a_st), 32'd1);
    chk("start_score", 32'(a_score), 32'd0);
    chk("start_time", 32'(a_time), 32'd3);
    step(130);
    @(negedge CLOCK_50);
    chk("timeout_state", 32'(a_st), 32'd2);
    chk("timeout_time", 32'(a_time), 32'd0);
    chk("maxmiss_state", 32'(b_st), 32'd2);

    // Clamp at zero, hits, held switch, penalty from 4 to 3.
    new_round(3'b001);
    switches[3] = 1'b1;
    step();
    @(negedge CLOCK_50);
    chk("clamp0", 32'(a_score), 32'd0);
    step();
    switches = '0;
    wait_lit(1, l0, l1, ok);
    if (ok) begin
      switches[l0] = 1'b1;
      step();
      @(negedge CLOCK_50);
      chk("hit1_led", 32'(a_leds[l0]), 32'd0);
      chk("hit1", 32'(a_score), 32'd1);
      step(10);
      @(negedge CLOCK_50);
      chk("hold", 32'(a_score), 32'd1);
      step();
      switches = '0;
    end
    do_hit(2, "hit2");
    do_hit(3, "hit3");
    do_hit(4, "hit4");
    id = -1;
    for (int i = 0; i < N; i++) if (id < 0 && m_life[0][i] == 0) id = i;
    if (id >= 0) begin
      switches[id] = 1'b1;
      step();
      @(negedge CLOCK_50);
      chk("penalty", 32'(a_score), 32'd3);
      step();
      switches = '0;
    end

    // Two lanes hit in the same cycle.
    new_round(3'b001);
    wait_lit(2, l0, l1, ok);
    if (ok) begin
      switches[l0] = 1'b1;
      switches[l1] = 1'b1;
      step();
      @(negedge CLOCK_50);
      chk("dual_hit", 32'(a_score), 32'd2);
      step();
      switches = '0;
    end

    // Hit lands on the very tick the lane would have expired.
    new_round(3'b001);
    ok = 1'b0;
    id = 0;
    for (int c = 0; c < 300 && !ok; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!ok && m_st[0] == 1 && m_life[0][i] == 1 && (cyc % TD) == TD - 1) begin
          ok = 1'b1; id = i;
        end
      end
      if (!ok) step();
    end
    chk("wait_edge", 32'(ok), 32'd1);
    if (ok) begin
      switches[id] = 1'b1;
      step();
      @(negedge CLOCK_50);
      chk("edge_led", 32'(a_leds[id]), 32'd0);
      chk("edge_nomiss", 32'(a_miss), 32'd0);
      chk("edge_score", 32'(a_score), 32'd1);
      step();
      switches = '0;
    end

    // Untouched lanes expire: first miss, then miss limit ends instance b.
    new_round(3'b001);
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (m_miss[0] >= 1) ok = 1'b1; else step();
    end
    chk("wait_miss", 32'(ok), 32'd1);
    @(negedge CLOCK_50);
    chk("miss1", 32'(a_miss), 32'd1);
    step();
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      if (m_miss[1] >= 2) ok = 1'b1; else step();
    end
    chk("wait_miss2", 32'(ok), 32'd1);
    @(negedge CLOCK_50);
    chk("miss_over", 32'(b_st), 32'd2);
    step();

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      start = 1'b0;
      lvl_req = 3'b0;
      rst = 1'b0;
      r = $urandom_range(0, 99);
      if (r < 25) begin
        id = -1;
        off = $urandom_range(0, N - 1);
        for (int k = 0; k < N; k++) begin
          j = (off + k) % N;
          if (id < 0 && m_st[0] == 1 && m_life[0][j] > 0 && !switches[j]) id = j;
        end
        if (id >= 0) switches[id] = 1'b1;
      end else if (r < 35) begin
        id = $urandom_range(0, N - 1);
        switches[id] = ~switches[id];
      end else if (r < 50) begin
        id = $urandom_range(0, N - 1);
        switches[id] = 1'b0;
      end
      if ($urandom_range(0, 59) == 0) lvl_req = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 79) == 0) start = 1'b1;
      if ($urandom_range(0, 899) == 0) rst = 1'b1;
      step();
    end
    start = 1'b0;
    lvl_req = 3'b0;
    rst = 1'b0;
    step(5);
    @(negedge CLOCK_50);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
